// File: rtl/resp_stream_pkg.sv
// Shared constants and entry layout for the response-capture stream FIFO:
// CSR addresses, CTRL/STATUS bit positions and the stored FIFO entry format.
package resp_stream_pkg;

    localparam logic [1:0] CSR_CTRL    = 2'd0;
    localparam logic [1:0] CSR_PKT_LEN = 2'd1;
    localparam logic [1:0] CSR_LEVEL   = 2'd2;
    localparam logic [1:0] CSR_STATUS  = 2'd3;

    localparam int CTRL_ENABLE_BIT     = 0;
    localparam int CTRL_FLUSH_BIT      = 1;
    localparam int STATUS_OVERFLOW_BIT = 0;
    localparam int STATUS_EMPTY_BIT    = 1;
    localparam int STATUS_FULL_BIT     = 2;

    localparam int PKT_LEN_W    = 8;
    localparam int ENTRY_DATA_W = 32;

    // Widest stream word supported; narrower OUT_W uses the low bits of data.
    typedef struct packed {
        logic                    sop;
        logic                    eop;
        logic [ENTRY_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/resp_sync_fifo.sv
// Show-ahead single-clock FIFO with full/empty/level and a synchronous clear
// that overrides any same-cycle push or pop.
module resp_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 64,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~o_full  & ~i_clear;
    assign w_pop  = i_pop  & ~o_empty & ~i_clear;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Head is read combinationally so a new word shows one cycle after its push.
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/resp_stream_fifo.sv
// Response capture -> packetiser -> FIFO -> Avalon-ST source, with a 4-register CSR.
// Optional macro RESP_SEQ_EN puts a wrapping sequence counter in the upper word field.
module resp_stream_fifo
    import resp_stream_pkg::*;
#(
    parameter int RESP_W = 11,
    parameter int OUT_W  = 32,
    parameter int DEPTH  = 64,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [RESP_W-1:0] resp_data,
    input  logic              resp_valid,
    input  logic [1:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [OUT_W-1:0]  csr_writedata,
    output logic [OUT_W-1:0]  csr_readdata,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_startofpacket,
    output logic              out_endofpacket
);

    localparam int UPPER_W = OUT_W - RESP_W;

    logic                 r_enable;
    logic [PKT_LEN_W-1:0] r_pkt_len;
    logic [PKT_LEN_W-1:0] r_pcnt;
    logic                 r_overflow;
    logic [OUT_W-1:0]     r_csr_readdata;

    logic                 w_full;
    logic                 w_empty;
    logic [LVL_W-1:0]     w_level;
    logic                 w_flush;
    logic                 w_cap_req;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_pop;
    logic                 w_sop;
    logic                 w_eop;
    logic [UPPER_W-1:0]   w_upper;
    logic [OUT_W-1:0]     w_word;
    logic [OUT_W+1:0]     w_rd_bits;
    logic [OUT_W-1:0]     w_rd_mux;
    fifo_entry_t          w_wr_ent;
    fifo_entry_t          w_head;
    logic                 w_unused;

    assign w_flush   = csr_write & (csr_address == CSR_CTRL) & csr_writedata[CTRL_FLUSH_BIT];
    assign w_cap_req = resp_valid & r_enable;
    assign w_accept  = w_cap_req & ~w_full & ~w_flush;
    assign w_drop    = w_cap_req & w_full;
    assign w_pop     = out_valid & out_ready;

    assign w_sop = (r_pcnt == '0);
    assign w_eop = (r_pcnt >= (r_pkt_len - 8'd1));

`ifdef RESP_SEQ_EN
    logic [UPPER_W-1:0] r_seq;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_seq <= '0;
        end else if (w_accept) begin
            r_seq <= r_seq + 1'b1;
        end
    end

    assign w_upper = r_seq;
`else
    assign w_upper = '0;
`endif

    assign w_word = {w_upper, resp_data};

    // pcnt only moves on accepted words, so disabled or dropped strobes hold the packet position.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_pcnt <= '0;
        end else if (w_flush) begin
            r_pcnt <= '0;
        end else if (w_accept) begin
            r_pcnt <= w_eop ? '0 : r_pcnt + 8'd1;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_enable   <= 1'b0;
            r_pkt_len  <= 8'd1;
            r_overflow <= 1'b0;
        end else begin
            if (csr_write && csr_address == CSR_CTRL) begin
                r_enable <= csr_writedata[CTRL_ENABLE_BIT];
            end
            if (csr_write && csr_address == CSR_PKT_LEN) begin
                r_pkt_len <= (csr_writedata[PKT_LEN_W-1:0] == '0) ? 8'd1 : csr_writedata[PKT_LEN_W-1:0];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (csr_write && csr_address == CSR_STATUS && csr_writedata[STATUS_OVERFLOW_BIT]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (csr_address)
            CSR_CTRL:    w_rd_mux[CTRL_ENABLE_BIT] = r_enable;
            CSR_PKT_LEN: w_rd_mux[PKT_LEN_W-1:0]   = r_pkt_len;
            CSR_LEVEL:   w_rd_mux[LVL_W-1:0]       = w_level;
            default: begin
                w_rd_mux[STATUS_OVERFLOW_BIT] = r_overflow;
                w_rd_mux[STATUS_EMPTY_BIT]    = w_empty;
                w_rd_mux[STATUS_FULL_BIT]     = w_full;
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_csr_readdata <= '0;
        end else if (csr_read) begin
            r_csr_readdata <= w_rd_mux;
        end
    end

    assign csr_readdata = r_csr_readdata;

    always_comb begin
        w_wr_ent      = '0;
        w_wr_ent.sop  = w_sop;
        w_wr_ent.eop  = w_eop;
        w_wr_ent.data = ENTRY_DATA_W'(w_word);
    end

    resp_sync_fifo #(
        .WIDTH (OUT_W + 2),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .i_clear (w_flush),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_wdata ({w_wr_ent.sop, w_wr_ent.eop, w_wr_ent.data[OUT_W-1:0]}),
        .o_rdata (w_rd_bits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_comb begin
        w_head      = '0;
        w_head.sop  = w_rd_bits[OUT_W+1];
        w_head.eop  = w_rd_bits[OUT_W];
        w_head.data = ENTRY_DATA_W'(w_rd_bits[OUT_W-1:0]);
    end

    assign out_valid         = ~w_empty;
    assign out_data          = out_valid ? w_head.data[OUT_W-1:0] : '0;
    assign out_startofpacket = out_valid & w_head.sop;
    assign out_endofpacket   = out_valid & w_head.eop;

    assign w_unused = ^{csr_writedata[OUT_W-1:PKT_LEN_W]};

endmodule

// File: tb/tb_resp_stream_fifo.sv
// Directed self-checking bench for resp_stream_fifo; expected words follow
// RESP_SEQ_EN when that macro is defined for the build.
module tb_resp_stream_fifo;

    localparam int RESP_W = 11;
    localparam int OUT_W  = 32;
    localparam int DEPTH  = 64;
    localparam int LVL_W  = 7;
`ifdef RESP_SEQ_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic [RESP_W-1:0] resp_data;
    logic              resp_valid;
    logic [1:0]        csr_address;
    logic              csr_read;
    logic              csr_write;
    logic [OUT_W-1:0]  csr_writedata;
    logic [OUT_W-1:0]  csr_readdata;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_startofpacket;
    logic              out_endofpacket;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned seq   = 0;
    logic [31:0] rd;

    resp_stream_fifo #(
        .RESP_W (RESP_W),
        .OUT_W  (OUT_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) dut (
        .clk_clk           (clk_clk),
        .reset_reset       (reset_reset),
        .resp_data         (resp_data),
        .resp_valid        (resp_valid),
        .csr_address       (csr_address),
        .csr_read          (csr_read),
        .csr_write         (csr_write),
        .csr_writedata     (csr_writedata),
        .csr_readdata      (csr_readdata),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket)
    );

    always #5 clk_clk = ~clk_clk;

    function automatic logic [31:0] exp_word(input int unsigned s, input logic [10:0] d);
        logic [20:0] up;
        up = SEQ_ON ? 21'(s) : 21'd0;
        return {up, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        tick();
        csr_write     = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_address = a;
        csr_read    = 1'b1;
        tick();
        d           = csr_readdata;
        csr_read    = 1'b0;
    endtask

    task automatic cap(input logic [10:0] d);
        resp_data  = d;
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] d, input logic s, input logic e);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(d));
        chk({tag, "_sop"}, 64'(out_startofpacket), 64'(s));
        chk({tag, "_eop"}, 64'(out_endofpacket), 64'(e));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset_reset   = 1'b1;
        resp_data     = '0;
        resp_valid    = 1'b0;
        csr_address   = '0;
        csr_read      = 1'b0;
        csr_write     = 1'b0;
        csr_writedata = '0;
        out_ready     = 1'b0;
        repeat (2) @(posedge clk_clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_sop", 64'(out_startofpacket), 64'd0);
        chk("rst_eop", 64'(out_endofpacket), 64'd0);
        chk("rst_rdata", 64'(csr_readdata), 64'd0);
        reset_reset = 1'b0;
        tick();
        csr_rd(2'd1, rd); chk("rst_pktlen", 64'(rd), 64'd1);
        csr_rd(2'd2, rd); chk("rst_level", 64'(rd), 64'd0);
        csr_rd(2'd3, rd); chk("rst_status", 64'(rd), 64'd2);
        csr_rd(2'd0, rd); chk("rst_ctrl", 64'(rd), 64'd0);

        // Packets of 3 over six captures
        csr_wr(2'd0, 32'h1);
        csr_wr(2'd1, 32'h3);
        cap(11'h001);
        chk("t1_latency", 64'(out_valid), 64'd1);
        for (int i = 2; i <= 6; i++) cap(11'(i));
        for (int k = 0; k < 6; k++) begin
            pop_chk("t1", exp_word(seq, 11'(k + 1)), (k % 3) == 0, (k % 3) == 2);
            seq++;
        end
        chk("t1_drained", 64'(out_valid), 64'd0);

        // Overfill: 70 captures into 64 entries
        for (int i = 0; i < 70; i++) cap(11'(i + 1));
        csr_rd(2'd2, rd); chk("t2_level", 64'(rd), 64'd64);
        csr_rd(2'd3, rd); chk("t2_status", 64'(rd), 64'h5);
        for (int k = 0; k < 64; k++) begin
            pop_chk("t2", exp_word(seq, 11'(k + 1)), (k % 3) == 0, (k % 3) == 2);
            seq++;
        end
        chk("t2_drained", 64'(out_valid), 64'd0);
        csr_rd(2'd3, rd); chk("t2_status_ovf", 64'(rd), 64'h3);
        csr_wr(2'd3, 32'h1);
        csr_rd(2'd3, rd); chk("t2_status_clr", 64'(rd), 64'h2);

        // Enable gap mid-packet
        csr_wr(2'd0, 32'h3);
        csr_wr(2'd1, 32'h4);
        cap(11'h010); cap(11'h011);
        csr_wr(2'd0, 32'h0);
        for (int i = 0; i < 5; i++) cap(11'(32'h20 + i));
        csr_wr(2'd0, 32'h1);
        cap(11'h012); cap(11'h013);
        csr_rd(2'd2, rd); chk("t3_level", 64'(rd), 64'd4);
        for (int k = 0; k < 4; k++) begin
            pop_chk("t3", exp_word(seq, 11'(32'h10 + k)), k == 0, k == 3);
            seq++;
        end
        chk("t3_drained", 64'(out_valid), 64'd0);

        // Flush with simultaneous capture and pop
        for (int i = 0; i < 5; i++) cap(11'(32'h30 + i));
        seq += 5;
        csr_address   = 2'd0;
        csr_writedata = 32'h3;
        csr_write     = 1'b1;
        resp_data     = 11'h035;
        resp_valid    = 1'b1;
        out_ready     = 1'b1;
        tick();
        csr_write  = 1'b0;
        resp_valid = 1'b0;
        out_ready  = 1'b0;
        chk("t4_valid", 64'(out_valid), 64'd0);
        chk("t4_data", 64'(out_data), 64'd0);
        csr_rd(2'd2, rd); chk("t4_level", 64'(rd), 64'd0);
        cap(11'h036);
        pop_chk("t4", exp_word(seq, 11'h036), 1'b1, 1'b0);
        seq++;
        csr_wr(2'd0, 32'h3);

        // Packet length shortened mid-packet
        csr_wr(2'd1, 32'h8);
        for (int i = 0; i < 5; i++) cap(11'(32'h40 + i));
        csr_wr(2'd1, 32'h2);
        cap(11'h045); cap(11'h046);
        for (int k = 0; k < 7; k++) begin
            pop_chk("t5", exp_word(seq, 11'(32'h40 + k)), (k == 0) || (k == 6), k == 5);
            seq++;
        end

        // Asynchronous reset mid-packet
        for (int i = 0; i < 10; i++) cap(11'(32'h50 + i));
        csr_rd(2'd2, rd); chk("t6_level", 64'(rd), 64'd10);
        #2;
        reset_reset = 1'b1;
        #1;
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_data", 64'(out_data), 64'd0);
        chk("t6_sop", 64'(out_startofpacket), 64'd0);
        chk("t6_eop", 64'(out_endofpacket), 64'd0);
        chk("t6_rdata", 64'(csr_readdata), 64'd0);
        tick();
        reset_reset = 1'b0;
        tick();
        csr_rd(2'd1, rd); chk("t6_pktlen", 64'(rd), 64'd1);
        csr_rd(2'd2, rd); chk("t6_level0", 64'(rd), 64'd0);
        csr_rd(2'd0, rd); chk("t6_ctrl", 64'(rd), 64'd0);
        cap(11'h07f);
        chk("t6_disabled", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
